// File: rtl/du_dump_tx.sv
// du_dump_tx: debug-unit transmit sequencer.
// On a halt/step-complete pulse, streams PC, the register bank and the data
// memory to the host, one word at a time, LSB byte first, over the UART TX
// valid/ready byte handshake.
// Optional build macro DU_DUMP_CHECKSUM_EN appends one XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for i_start, o_busy low
// SEND   | presenting buffer byte[idx] on the TX handshake
// FETCH  | read address on the rf/dm port (dm read enable pulsed)
// WAIT   | read data captured into the word buffer, word index advanced
// CKSUM  | (checksum build only) presenting the XOR byte
// FIN    | one-cycle o_done, then back to IDLE
module du_dump_tx #(
  parameter int NB_DATA           = 32,
  parameter int NB_TX             = 8,
  parameter int N_REGS            = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int N_D_MEM_ADDR      = 64,
  parameter int NB_D_MEM_ADDR     = $clog2(N_D_MEM_ADDR)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [NB_DATA-1:0]           i_pc,
  output logic [NB_ADDR_REGISTERS-1:0] o_rf_addr,
  input  logic [NB_DATA-1:0]           i_rf_data,
  output logic [NB_D_MEM_ADDR-1:0]     o_dm_addr,
  output logic                         o_dm_r_en,
  input  logic [NB_DATA-1:0]           i_dm_data,
  output logic [NB_TX-1:0]             o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_TX;
  localparam int NB_BIDX        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [NB_BIDX-1:0]           LAST_BIDX = NB_BIDX'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR_REGISTERS-1:0] LAST_REG  = NB_ADDR_REGISTERS'(N_REGS - 1);
  localparam logic [NB_D_MEM_ADDR-1:0]     LAST_MEM  = NB_D_MEM_ADDR'(N_D_MEM_ADDR - 1);

`ifdef DU_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_FETCH, ST_WAIT, ST_CKSUM, ST_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_FETCH, ST_WAIT, ST_FIN
  } state_t;
`endif

  typedef enum logic [1:0] {
    SEC_PC, SEC_REG, SEC_MEM
  } section_t;

  state_t                       state_q, state_d;
  section_t                     sect_q, sect_d;
  logic [NB_DATA-1:0]           buf_q, buf_d;
  logic [NB_BIDX-1:0]           bidx_q, bidx_d;
  logic [NB_ADDR_REGISTERS-1:0] rf_idx_q, rf_idx_d;
  logic [NB_D_MEM_ADDR-1:0]     dm_idx_q, dm_idx_d;
  // set once the final memory word is in the buffer; the index has wrapped by then
  logic                         last_q, last_d;
`ifdef DU_DUMP_CHECKSUM_EN
  logic [NB_TX-1:0]             cksum_q, cksum_d;
`endif

  logic [NB_TX-1:0] cur_byte;

  // byte of the word buffer selected by the byte index
  always_comb begin
    cur_byte = buf_q[bidx_q*NB_TX +: NB_TX];
  end

  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      sect_q   <= SEC_PC;
      buf_q    <= '0;
      bidx_q   <= '0;
      rf_idx_q <= '0;
      dm_idx_q <= '0;
      last_q   <= 1'b0;
`ifdef DU_DUMP_CHECKSUM_EN
      cksum_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sect_q   <= sect_d;
      buf_q    <= buf_d;
      bidx_q   <= bidx_d;
      rf_idx_q <= rf_idx_d;
      dm_idx_q <= dm_idx_d;
      last_q   <= last_d;
`ifdef DU_DUMP_CHECKSUM_EN
      cksum_q  <= cksum_d;
`endif
    end
  end

  // next-state logic and handshake outputs
  always_comb begin
    state_d    = state_q;
    sect_d     = sect_q;
    buf_d      = buf_q;
    bidx_d     = bidx_q;
    rf_idx_d   = rf_idx_q;
    dm_idx_d   = dm_idx_q;
    last_d     = last_q;
`ifdef DU_DUMP_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    o_dm_r_en  = 1'b0;
    o_done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          buf_d    = i_pc;
          bidx_d   = '0;
          sect_d   = SEC_PC;
          rf_idx_d = '0;
          dm_idx_d = '0;
          last_d   = 1'b0;
`ifdef DU_DUMP_CHECKSUM_EN
          cksum_d  = '0;
`endif
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cur_byte;
        if (i_tx_ready) begin
`ifdef DU_DUMP_CHECKSUM_EN
          cksum_d = cksum_q ^ cur_byte;
`endif
          if (bidx_q == LAST_BIDX) begin
            bidx_d = '0;
            if (last_q) begin
`ifdef DU_DUMP_CHECKSUM_EN
              state_d = ST_CKSUM;
`else
              state_d = ST_FIN;
`endif
            end else begin
              state_d = ST_FETCH;
              // the PC word has no read port; registers follow it
              if (sect_q == SEC_PC) begin
                sect_d = SEC_REG;
              end
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end

      ST_FETCH: begin
        o_dm_r_en = (sect_q == SEC_MEM);
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (sect_q == SEC_MEM) begin
          buf_d = i_dm_data;
          if (dm_idx_q == LAST_MEM) begin
            dm_idx_d = '0;
            last_d   = 1'b1;
          end else begin
            dm_idx_d = dm_idx_q + 1'b1;
          end
        end else begin
          buf_d = i_rf_data;
          if (rf_idx_q == LAST_REG) begin
            rf_idx_d = '0;
            sect_d   = SEC_MEM;
          end else begin
            rf_idx_d = rf_idx_q + 1'b1;
          end
        end
        state_d = ST_SEND;
      end

`ifdef DU_DUMP_CHECKSUM_EN
      ST_CKSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cksum_q;
        if (i_tx_ready) begin
          state_d = ST_FIN;
        end
      end
`endif

      ST_FIN: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // read addresses hold the current word index; they only move in WAIT
  always_comb begin
    o_rf_addr = rf_idx_q;
    o_dm_addr = dm_idx_q;
    o_busy    = (state_q != ST_IDLE);
  end

endmodule
